// File: rtl/cpu_pkg.sv
// Shared definitions for the integer write-back path: register-file geometry,
// the write-request record and the round-robin source encodings.
package cpu_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 64;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {
    SRC_EXU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Busy scoreboard for the register file: one bit per register marking a write in
// flight, set by issue, cleared by the register-file write, queried by issue.
module wb_scoreboard
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int NREGS      = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en_i,
  input  logic [ADDR_WIDTH-1:0] set_addr_i,
  input  logic                  clr_en_i,
  input  logic [ADDR_WIDTH-1:0] clr_addr_i,
  input  logic [ADDR_WIDTH-1:0] rs1_i,
  input  logic [ADDR_WIDTH-1:0] rs2_i,
  output logic                  rs1_busy_o,
  output logic                  rs2_busy_o
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Clear is applied before set so that a newly issued writer to the same
  // register keeps it busy when the older write retires in the same cycle.
  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) begin
      busy_d[clr_addr_i] = 1'b0;
    end
    if (set_en_i && (set_addr_i != REG_ZERO)) begin
      busy_d[set_addr_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign rs1_busy_o = busy_q[rs1_i];
  assign rs2_busy_o = busy_q[rs2_i];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back master for the integer register file: round-robin merge of EXU and
// LSU results into the single registered RF write port, plus the busy scoreboard.
module rf_wb_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata
);

  localparam int NREGS = 1 << ADDR_WIDTH;

  src_e                  rr_q;
  logic                  wen_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic    exu_hs;
  logic    lsu_hs;
  logic    any_hs;
  logic    contended;
  wb_req_t req_sel;

  // A source wins outright when alone; under contention rr_q names the winner.
  always_comb begin
    contended = exu_valid & lsu_valid;
    exu_ready = exu_valid & (~lsu_valid | (rr_q == SRC_EXU));
    lsu_ready = lsu_valid & (~exu_valid | (rr_q == SRC_LSU));
    exu_hs    = exu_valid & exu_ready;
    lsu_hs    = lsu_valid & lsu_ready;
    any_hs    = exu_hs | lsu_hs;
    req_sel   = '0;
    if (exu_hs) begin
      req_sel.rd   = exu_rd;
      req_sel.data = exu_data;
    end else if (lsu_hs) begin
      req_sel.rd   = lsu_rd;
      req_sel.data = lsu_data;
    end
  end

  // Address/data only move on a handshake so the RF port stays quiet otherwise;
  // x0 results still complete their handshake but never raise the write enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q    <= SRC_EXU;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      wen_q <= any_hs && (req_sel.rd != REG_ZERO);
      if (any_hs) begin
        waddr_q <= req_sel.rd;
        wdata_q <= req_sel.data;
      end
      if (contended && any_hs) begin
        rr_q <= exu_hs ? SRC_LSU : SRC_EXU;
      end
    end
  end

  assign rf_wen   = wen_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;

  wb_scoreboard #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .NREGS     (NREGS)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_en_i  (iss_valid),
    .set_addr_i(iss_rd),
    .clr_en_i  (wen_q),
    .clr_addr_i(waddr_q),
    .rs1_i     (rs1),
    .rs2_i     (rs2),
    .rs1_busy_o(rs1_busy),
    .rs2_busy_o(rs2_busy)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: expected RF writes go into a queue that a
// negedge monitor drains; readies and busy bits are checked inline.
module tb_rf_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        exu_valid;
  logic        exu_ready;
  logic [4:0]  exu_rd;
  logic [63:0] exu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [63:0] lsu_data;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;

  typedef struct {
    logic [4:0]  addr;
    logic [63:0] data;
  } exp_wr_t;

  exp_wr_t expQ[$];
  int      checkCount = 0;
  int      failCount  = 0;

  rf_wb_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .exu_valid(exu_valid),
    .exu_ready(exu_ready),
    .exu_rd   (exu_rd),
    .exu_data (exu_data),
    .lsu_valid(lsu_valid),
    .lsu_ready(lsu_ready),
    .lsu_rd   (lsu_rd),
    .lsu_data (lsu_data),
    .iss_valid(iss_valid),
    .iss_rd   (iss_rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rf_wen   (rf_wen),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge, then apply the new inputs.
  task automatic applyStimulus(input logic r,
                               input logic ev, input logic [4:0] erd, input logic [63:0] ed,
                               input logic lv, input logic [4:0] lrd, input logic [63:0] ld,
                               input logic iv, input logic [4:0] ird);
    @(posedge clk);
    #1;
    rst       = r;
    exu_valid = ev;
    exu_rd    = erd;
    exu_data  = ed;
    lsu_valid = lv;
    lsu_rd    = lrd;
    lsu_data  = ld;
    iss_valid = iv;
    iss_rd    = ird;
  endtask

  task automatic pushWrite(input logic [4:0] a, input logic [63:0] d);
    exp_wr_t e;
    e.addr = a;
    e.data = d;
    expQ.push_back(e);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
  endtask

  // Monitor: every asserted RF write must match the oldest expected write.
  initial begin
    exp_wr_t e;
    forever begin
      @(negedge clk);
      if (!rst && rf_wen === 1'b1) begin
        checkCount++;
        if (expQ.size() == 0) begin
          failCount++;
          $display("[TB] FAIL unexpected_write: got waddr=%0d wdata=0x%0h, expected no write", rf_waddr, rf_wdata);
        end else begin
          e = expQ.pop_front();
          checkOutput("wb_waddr", {59'd0, rf_waddr}, {59'd0, e.addr});
          checkOutput("wb_wdata", rf_wdata, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    failCount++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

  initial begin
    rst = 1'b1; exu_valid = 1'b1; exu_rd = 5'd0; exu_data = 64'h55;
    lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 64'd0;
    iss_valid = 1'b0; iss_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;

    // Reset held for two edges with EXU valid (rd=0, so no write results).
    applyStimulus(1'b1, 1'b1, 5'd0, 64'h55, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    applyStimulus(1'b0, 1'b1, 5'd0, 64'h55, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    @(negedge clk);
    checkOutput("reset_wen", {63'd0, rf_wen}, 64'd0);
    checkOutput("reset_waddr", {59'd0, rf_waddr}, 64'd0);
    checkOutput("reset_wdata", rf_wdata, 64'd0);
    checkOutput("reset_rs1_busy", {63'd0, rs1_busy}, 64'd0);
    checkOutput("reset_rs2_busy", {63'd0, rs2_busy}, 64'd0);
    checkOutput("reset_exu_ready", {63'd0, exu_ready}, 64'd1);

    // Single EXU write, latency one cycle.
    applyStimulus(1'b0, 1'b1, 5'd5, 64'hDEAD, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    pushWrite(5'd5, 64'hDEAD);
    @(negedge clk);
    checkOutput("exu_ready_alone", {63'd0, exu_ready}, 64'd1);
    idle();
    @(negedge clk);
    checkOutput("exu_wen_n1", {63'd0, rf_wen}, 64'd1);
    checkOutput("exu_waddr_n1", {59'd0, rf_waddr}, 64'd5);
    idle();
    @(negedge clk);
    checkOutput("exu_wen_n2", {63'd0, rf_wen}, 64'd0);
    checkOutput("hold_waddr", {59'd0, rf_waddr}, 64'd5);
    checkOutput("hold_wdata", rf_wdata, 64'hDEAD);

    // Contention: EXU favoured first, then alternation; loser holds its request.
    applyStimulus(1'b0, 1'b1, 5'd1, 64'h1111, 1'b1, 5'd7, 64'h7777, 1'b0, 5'd0);
    pushWrite(5'd1, 64'h1111);
    @(negedge clk);
    checkOutput("c1_exu_ready", {63'd0, exu_ready}, 64'd1);
    checkOutput("c1_lsu_ready", {63'd0, lsu_ready}, 64'd0);
    applyStimulus(1'b0, 1'b1, 5'd2, 64'h2222, 1'b1, 5'd7, 64'h7777, 1'b0, 5'd0);
    pushWrite(5'd7, 64'h7777);
    @(negedge clk);
    checkOutput("c2_exu_ready", {63'd0, exu_ready}, 64'd0);
    checkOutput("c2_lsu_ready", {63'd0, lsu_ready}, 64'd1);
    applyStimulus(1'b0, 1'b1, 5'd2, 64'h2222, 1'b1, 5'd8, 64'h8888, 1'b0, 5'd0);
    pushWrite(5'd2, 64'h2222);
    @(negedge clk);
    checkOutput("c3_exu_ready", {63'd0, exu_ready}, 64'd1);
    checkOutput("c3_lsu_ready", {63'd0, lsu_ready}, 64'd0);

    // LSU alone to x0: accepted, no write.
    applyStimulus(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'hBAD0, 1'b0, 5'd0);
    @(negedge clk);
    checkOutput("x0_lsu_ready", {63'd0, lsu_ready}, 64'd1);
    idle();
    @(negedge clk);
    checkOutput("x0_no_wen", {63'd0, rf_wen}, 64'd0);
    checkOutput("x0_waddr_zero", {59'd0, rf_waddr}, 64'd0);

    // Issue to x0 never marks busy.
    rs1 = 5'd0;
    applyStimulus(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd0);
    idle();
    @(negedge clk);
    checkOutput("x0_rs1_busy", {63'd0, rs1_busy}, 64'd0);

    // Scoreboard set, then cleared by the retiring write.
    rs1 = 5'd10;
    rs2 = 5'd11;
    applyStimulus(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd10);
    @(negedge clk);
    checkOutput("sb_busy_before", {63'd0, rs1_busy}, 64'd0);
    applyStimulus(1'b0, 1'b1, 5'd10, 64'hA0A0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    pushWrite(5'd10, 64'hA0A0);
    @(negedge clk);
    checkOutput("sb_busy_set", {63'd0, rs1_busy}, 64'd1);
    checkOutput("sb_rs2_idle", {63'd0, rs2_busy}, 64'd0);
    idle();
    @(negedge clk);
    checkOutput("sb_busy_during_wen", {63'd0, rs1_busy}, 64'd1);
    idle();
    @(negedge clk);
    checkOutput("sb_busy_cleared", {63'd0, rs1_busy}, 64'd0);

    // Set wins over clear on the same register in the same cycle.
    rs2 = 5'd10;
    applyStimulus(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd10);
    applyStimulus(1'b0, 1'b1, 5'd10, 64'hB0B0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    pushWrite(5'd10, 64'hB0B0);
    applyStimulus(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd10);
    @(negedge clk);
    checkOutput("prio_wen", {63'd0, rf_wen}, 64'd1);
    idle();
    @(negedge clk);
    checkOutput("prio_busy_kept", {63'd0, rs2_busy}, 64'd1);

    // Reset during a handshake drops the write and clears busy.
    applyStimulus(1'b1, 1'b1, 5'd4, 64'h4444, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    idle();
    @(negedge clk);
    checkOutput("rstmid_wen", {63'd0, rf_wen}, 64'd0);
    checkOutput("rstmid_busy", {63'd0, rs1_busy}, 64'd0);

    idle();
    idle();
    @(negedge clk);
    checkOutput("pending_writes", 64'(expQ.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
